// File: rtl/line_engine.sv
// line_engine: Bresenham line rasteriser writing one pixel per accepted
// framebuffer handshake. Coordinates live in a 256x256 space and each
// pixel address is {y, x}.
//
// Build option LINE_ENGINE_PLOT_END_EN:
//   defined   - the end pixel is written (max(dx,|dy|)+1 writes)
//   undefined - the end pixel is suppressed (max(dx,|dy|) writes); a
//               zero-length line goes straight from SETUP to DONE
module line_engine (
    input  logic        pclk,
    input  logic        rst,
    input  logic        go,
    input  logic [7:0]  stax,
    input  logic [7:0]  stay,
    input  logic [7:0]  endx,
    input  logic [7:0]  endy,
    input  logic [3:0]  beam,
    input  logic        fb_ready,
    output logic        busy,
    output logic        fb_we,
    output logic [15:0] fb_addr,
    output logic [3:0]  fb_data,
    output logic        done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_DRAW  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [7:0]         r_x;
    logic [7:0]         r_y;
    logic [7:0]         r_ex;
    logic [7:0]         r_ey;
    logic [3:0]         r_beam;
    logic signed [10:0] r_dx;
    logic signed [10:0] r_dy;
    logic signed [10:0] r_err;
    logic               r_sxneg;
    logic               r_syneg;

    logic signed [10:0] w_ddx;
    logic signed [10:0] w_ddy;
    logic signed [10:0] w_adx;
    logic signed [10:0] w_ady;
    logic signed [10:0] w_e2;
    logic               w_stepx;
    logic               w_stepy;
    logic signed [10:0] w_err_nx;
    logic [7:0]         w_nx;
    logic [7:0]         w_ny;
    logic               w_at_end;
    logic               w_next_end;
    logic               w_last;
    logic               w_zero_len;
    logic               w_accept;

    // Setup-time deltas and the per-step Bresenham update for the current pixel
    always_comb begin
        w_ddx      = $signed({3'b000, r_ex}) - $signed({3'b000, r_x});
        w_ddy      = $signed({3'b000, r_ey}) - $signed({3'b000, r_y});
        w_adx      = w_ddx[10] ? -w_ddx : w_ddx;
        w_ady      = w_ddy[10] ? -w_ddy : w_ddy;
        // |err| never exceeds 2*255, so doubling stays inside 11 bits
        w_e2       = r_err <<< 1;
        w_stepx    = (w_e2 >= r_dy);
        w_stepy    = (w_e2 <= r_dx);
        w_err_nx   = r_err + (w_stepx ? r_dy : 11'sd0) + (w_stepy ? r_dx : 11'sd0);
        w_nx       = r_x;
        w_ny       = r_y;
        if (w_stepx) w_nx = r_sxneg ? (r_x - 8'd1) : (r_x + 8'd1);
        if (w_stepy) w_ny = r_syneg ? (r_y - 8'd1) : (r_y + 8'd1);
        w_at_end   = (r_x == r_ex) && (r_y == r_ey);
        w_next_end = (w_nx == r_ex) && (w_ny == r_ey);
        w_zero_len = w_at_end;
        w_accept   = (r_state == S_DRAW) && fb_ready;
`ifdef LINE_ENGINE_PLOT_END_EN
        w_last     = w_at_end;
`else
        // Stop on the write that precedes the end pixel so it is never issued
        w_last     = w_next_end;
`endif
    end

    // Control FSM and line state; inputs are only sampled in IDLE
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_ex    <= '0;
            r_ey    <= '0;
            r_beam  <= '0;
            r_dx    <= '0;
            r_dy    <= '0;
            r_err   <= '0;
            r_sxneg <= 1'b0;
            r_syneg <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_x     <= stax;
                        r_y     <= stay;
                        r_ex    <= endx;
                        r_ey    <= endy;
                        r_beam  <= beam;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_dx    <= w_adx;
                    r_dy    <= -w_ady;
                    r_err   <= w_adx - w_ady;
                    r_sxneg <= w_ddx[10];
                    r_syneg <= w_ddy[10];
`ifdef LINE_ENGINE_PLOT_END_EN
                    r_state <= S_DRAW;
`else
                    r_state <= w_zero_len ? S_DONE : S_DRAW;
`endif
                end
                S_DRAW: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_x   <= w_nx;
                            r_y   <= w_ny;
                            r_err <= w_err_nx;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode purely from registers, so fb_ready never reaches them
    always_comb begin
        busy    = (r_state == S_SETUP) || (r_state == S_DRAW);
        fb_we   = (r_state == S_DRAW);
        fb_addr = {r_y, r_x};
        fb_data = r_beam;
        done    = (r_state == S_DONE);
    end

endmodule

// File: tb/tb_line_engine.sv
// Directed testbench for line_engine; expected values are hand-derived
// per line and adapt to the LINE_ENGINE_PLOT_END_EN build option.
module tb_line_engine;

    logic        pclk = 1'b0;
    logic        rst;
    logic        go;
    logic [7:0]  stax, stay, endx, endy;
    logic [3:0]  beam;
    logic        fb_ready;
    logic        busy;
    logic        fb_we;
    logic [15:0] fb_addr;
    logic [3:0]  fb_data;
    logic        done;

`ifdef LINE_ENGINE_PLOT_END_EN
    localparam int PE = 1;
`else
    localparam int PE = 0;
`endif

    line_engine dut (
        .pclk     (pclk),
        .rst      (rst),
        .go       (go),
        .stax     (stax),
        .stay     (stay),
        .endx     (endx),
        .endy     (endy),
        .beam     (beam),
        .fb_ready (fb_ready),
        .busy     (busy),
        .fb_we    (fb_we),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .done     (done)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] wr_addr[$];
    int first_we;
    int done_cnt;
    int hold_cnt;
    int data_bad;
    int busy_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Draw one line, collecting accepted addresses. stall_at: index of the
    // write to stall for 3 cycles (-1 none). go_at: write index at which a
    // stray go with different coordinates is pulsed (-1 none).
    task automatic run_line(input logic [7:0] ax, input logic [7:0] ay,
                            input logic [7:0] bx, input logic [7:0] by,
                            input logic [3:0] bm, input int stall_at, input int go_at);
        int          stall_left;
        bit          go_done;
        bit          stall_checked;
        logic [15:0] held;
        wr_addr.delete();
        first_we = -1; done_cnt = 0; hold_cnt = 0; data_bad = 0; busy_bad = 0;
        stall_left = 3; go_done = 0; stall_checked = 0; held = '0;
        @(negedge pclk);
        stax = ax; stay = ay; endx = bx; endy = by; beam = bm; go = 1'b1; fb_ready = 1'b1;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            @(negedge pclk);
            go = 1'b0;
            if (cyc == 1) begin
                stax = ~ax; stay = ~ay; endx = ~bx; endy = ~by; beam = ~bm;
            end
            if (done) begin
                done_cnt++;
                check("done_busy", busy, 1'b0);
                check("done_we", fb_we, 1'b0);
                break;
            end
            if (!busy) busy_bad++;
            if (go_at >= 0 && wr_addr.size() == go_at && !go_done) begin
                go = 1'b1; stax = 8'd0; stay = 8'd0; endx = 8'd10; endy = 8'd10;
                go_done = 1;
            end
            fb_ready = 1'b1;
            if (fb_we) begin
                if (first_we < 0) first_we = cyc;
                if (fb_data !== bm) data_bad++;
                if (stall_at >= 0 && wr_addr.size() == stall_at && stall_left > 0) begin
                    if (stall_left == 3) held = fb_addr;
                    else if (fb_addr === held) hold_cnt++;
                    fb_ready = 1'b0;
                    stall_left--;
                end else begin
                    if (stall_at >= 0 && stall_left == 0 && !stall_checked) begin
                        if (fb_addr === held) hold_cnt++;
                        stall_checked = 1;
                    end
                    wr_addr.push_back(fb_addr);
                end
            end
        end
        if (done_cnt == 0) check("timeout_done", 32'd0, 32'd1);
        @(negedge pclk);
        check("done_single", done, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("busy_during", busy_bad, 0);
        check("data_beam", data_bad, 0);
    endtask

    // Vertical line (128,126)->(128,100): x fixed, y counts down from 126
    task automatic check_vertical(input string tag);
        logic [7:0] yv;
        check({tag, "_count"}, wr_addr.size(), 26 + PE);
        for (int i = 0; i < wr_addr.size() && i < 26 + PE; i++) begin
            yv = 8'(126 - i);
            check({tag, "_addr"}, wr_addr[i], {yv, 8'd128});
        end
        check({tag, "_first_we"}, first_we, 2);
    endtask

    initial begin
        logic [7:0] v;
        int         ydec;
        int         seen_done;
        int         seen_we;

        rst = 1'b1; go = 1'b0; fb_ready = 1'b1;
        stax = '0; stay = '0; endx = '0; endy = '0; beam = '0;
        repeat (2) @(negedge pclk);
        check("rst_busy", busy, 1'b0);
        check("rst_we", fb_we, 1'b0);
        check("rst_addr", fb_addr, 16'h0000);
        check("rst_data", fb_data, 4'h0);
        check("rst_done", done, 1'b0);
        rst = 1'b0;

        // Vertical, upward-decreasing y
        run_line(8'd128, 8'd126, 8'd128, 8'd100, 4'hF, -1, -1);
        check_vertical("vert");
        check("vert_done", done_cnt, 1);

        // Diagonal, x == y on every write
        run_line(8'd130, 8'd130, 8'd156, 8'd156, 4'h7, -1, -1);
        check("diag_count", wr_addr.size(), 26 + PE);
        for (int i = 0; i < wr_addr.size() && i < 26 + PE; i++) begin
            v = 8'(130 + i);
            check("diag_addr", wr_addr[i], {v, v});
        end
        check("diag_done", done_cnt, 1);

        // Shallow line, both directions negative
        run_line(8'd125, 8'd127, 8'd100, 8'd114, 4'h9, -1, -1);
        check("shal_count", wr_addr.size(), 25 + PE);
        ydec = 0;
        for (int i = 0; i < wr_addr.size(); i++) begin
            v = 8'(125 - i);
            check("shal_x", wr_addr[i][7:0], v);
            if (i > 0 && wr_addr[i][15:8] == wr_addr[i-1][15:8] - 8'd1) ydec++;
        end
        check("shal_ydec", ydec, 12 + PE);
        if (wr_addr.size() > 0)
            check("shal_last", wr_addr[wr_addr.size()-1], (PE == 1) ? 16'h7264 : 16'h7365);
        check("shal_first", (wr_addr.size() > 0) ? wr_addr[0] : 16'hFFFF, 16'h7F7D);

        // Framebuffer back-pressure on the fifth write
        run_line(8'd128, 8'd126, 8'd128, 8'd100, 4'hF, 4, -1);
        check_vertical("stall");
        check("stall_hold", hold_cnt, 3);

        // Stray go while drawing is ignored
        run_line(8'd128, 8'd126, 8'd128, 8'd100, 4'hF, -1, 3);
        check_vertical("gomid");

        // Reset mid-draw aborts with no done pulse
        @(negedge pclk);
        stax = 8'd128; stay = 8'd126; endx = 8'd128; endy = 8'd100; beam = 4'hF;
        go = 1'b1; fb_ready = 1'b1;
        @(negedge pclk);
        go = 1'b0;
        repeat (4) @(negedge pclk);
        check("abort_pre_we", fb_we, 1'b1);
        rst = 1'b1;
        @(negedge pclk);
        rst = 1'b0;
        check("abort_we", fb_we, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_addr", fb_addr, 16'h0000);
        check("abort_data", fb_data, 4'h0);
        check("abort_done", done, 1'b0);
        seen_done = 0; seen_we = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge pclk);
            if (done) seen_done++;
            if (fb_we) seen_we++;
        end
        check("abort_no_done", seen_done, 0);
        check("abort_no_we", seen_we, 0);

        // Reset wins over go in the same cycle
        rst = 1'b1; go = 1'b1;
        @(negedge pclk);
        rst = 1'b0; go = 1'b0;
        @(negedge pclk);
        check("rstgo_busy", busy, 1'b0);

        // Zero-length line
        run_line(8'd50, 8'd50, 8'd50, 8'd50, 4'h3, -1, -1);
        check("pt_count", wr_addr.size(), PE);
        if (PE == 1 && wr_addr.size() > 0) check("pt_addr", wr_addr[0], 16'h3232);
        check("pt_done", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/line_engine.md
LINE_ENGINE -- requirements
Module: line_engine

Interface
REQ-001 Interface SHALL use one clock, and reset SHALL be synchronous and active-high.
REQ-002 pclk  input  1  pixel clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 go  input  1  single-cycle start pulse from the register file (BUSY register, bit 0 written 1).
REQ-005 stax, stay, endx, endy  input  8 each  start and end coordinates, 256x256 space.
REQ-006 beam  input  4  draw intensity (BEAM register).
REQ-007 fb_ready  input  1  framebuffer accepts a write this cycle.
REQ-008 busy  output  1  engine is drawing; mirrored to the BUSY register readback.
REQ-009 fb_we  output  1  pixel write request.
REQ-010 fb_addr  output  16  pixel address {y[7:0], x[7:0]}.
REQ-011 fb_data  output  4  pixel intensity.
REQ-012 done  output  1  one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have the states IDLE, SETUP, DRAW and DONE.
REQ-014 In IDLE, go=1 SHALL latch stax/stay/endx/endy/beam and move to SETUP, with busy=1 from the next cycle.
REQ-015 In SETUP (1 cycle), the engine SHALL compute dx=|endx-stax|, dy=-|endy-stay|, sx/sy=+1 or -1 by direction, and err=dx+dy. Arithmetic SHALL be 11-bit signed; no overflow SHALL be possible.
REQ-016 The first fb_we SHALL assert 2 cycles after the go cycle.
REQ-017 In DRAW, fb_we=1, fb_addr={y,x} and fb_data=latched beam. A write is accepted when fb_we&fb_ready.
REQ-018 On an accepted write at x==endx and y==endy, the FSM SHALL go to DONE. Otherwise it SHALL compute e2=2*err and apply both of the following in the same cycle using the pre-update err: if e2>=dy then err+=dy, x+=sx; if e2<=dx then err+=dx, y+=sy.
REQ-019 While fb_we=1 and fb_ready=0, fb_addr, fb_data, x, y and err SHALL hold unchanged; there SHALL be no combinational path from fb_ready to outputs.
REQ-020 In DONE (1 cycle), done=1, fb_we=0 and busy=0; the FSM SHALL then return to IDLE. busy SHALL fall in the same cycle done rises.
REQ-021 go asserted in SETUP/DRAW/DONE SHALL be ignored, with no relatch; input coordinate changes while busy SHALL have no effect.
REQ-022 With PLOT_END (REQ-026), the write count SHALL be max(dx,|dy|)+1 for every octant.
REQ-023 Coordinates SHALL never wrap: x and y stay within the span between start and end.

Reset
REQ-024 rst=1 SHALL force IDLE with busy=0, fb_we=0, fb_addr=0, fb_data=0 and done=0 on the next edge, including mid-DRAW (line aborted, no done pulse).
REQ-025 rst SHALL take priority over go in the same cycle.

Configuration
REQ-026 Macro LINE_ENGINE_PLOT_END_EN: when defined, the end pixel SHALL be written. When undefined, the end pixel SHALL be suppressed, so the write count is max(dx,|dy|); in that case start==end SHALL produce zero writes, DRAW is skipped (SETUP to DONE), and done still pulses.

Verification
REQ-027 Macro defined, fb_ready=1, beam=F, (128,126)->(128,100): expect 27 writes, x=128, y from 126 down to 100, data F; busy high from go+1 until the done cycle.
REQ-028 (130,130)->(156,156): expect 27 writes, each with x==y, from 130 up to 156, then one done pulse.
REQ-029 (125,127)->(100,114): expect 26 writes, x decrements every write, y decrements 13 times, last fb_addr=0x7264.
REQ-030 Same line as REQ-027 with fb_ready low for 3 cycles at write 5: expect the identical address sequence, outputs held for 3 cycles, total 27 accepted writes.
REQ-031 go pulsed during DRAW: expect no effect. Then rst during DRAW: next cycle fb_we=0 and busy=0, and no done pulse.
REQ-032 (50,50)->(50,50): expect exactly one write to 0x3232 with the macro defined, zero writes without it; done pulses once in both builds.
